fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one 32-bit FIFO write port among NUM_REQ producers. It grants one producer at a time for a burst of up to MAX_BURST words and muxes that producer's data onto the FIFO write interface. It obeys FIFO full backpressure so no write is ever issued into a full FIFO. It sits between producer blocks and the FIFO's wr/data_in/full pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, data word width
MAX_BURST, 4, max words accepted per grant (1..15)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester write request; held high while the requester has data
req_data  in  NUM_REQ*DATA_W  packed requester data; slice i = req_data[i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  marks the current word as the final word of the requester's burst
gnt  out  NUM_REQ  one-hot grant, registered
ack  out  NUM_REQ  word accepted this cycle (combinational)
fifo_full  in  1  FIFO full flag
fifo_wr  out  1  FIFO write strobe
fifo_data  out  DATA_W  FIFO write data
owner  out  $clog2(NUM_REQ)  index of the current grantee; 0 when idle
busy  out  1  high in BURST state

Behaviour:
- Reset: applies on the clock edge when reset_n=0.
  - gnt=0, owner=0, busy=0, state=IDLE, beat_cnt=0, last_owner=NUM_REQ-1 (requester 0 has first priority).
  - fifo_wr, ack and fifo_data derive from state, so all read 0 during reset.
  - A reset in mid-burst drops the burst immediately; no fifo_wr is issued in the reset cycle.
- States: IDLE, BURST.
- IDLE:
  - If any req bit is set, select the first set bit scanning from (last_owner+1) mod NUM_REQ upward with wrap.
  - Next edge: gnt[sel]=1, owner=sel, beat_cnt=0, state=BURST.
  - Latency from req to gnt is 1 cycle. No write occurs in IDLE.
- BURST, with o = owner:
  - fifo_wr = req[o] & ~fifo_full (combinational).
  - ack[o] = fifo_wr; all other ack bits are 0.
  - fifo_data = req_data slice o while in BURST, else 0.
  - On each accepted word, beat_cnt increments (4-bit counter, no wrap within one burst).
- Burst end: the burst ends at the edge following any of these:
  - (a) an accepted word with req_last[o]=1
  - (b) an accepted word that makes beat_cnt+1 == MAX_BURST
  - (c) req[o]=0 (requester withdrew; no word taken)
- On burst end: state=IDLE, gnt=0, last_owner=o, busy=0.
  - Re-arbitration therefore costs at least 1 idle cycle between grants.
- fifo_full=1 in BURST: stall. No ack, beat_cnt holds, grant is kept, no timeout.
- Fairness: the requester that just finished has the lowest priority next time. A lone requester is granted again after 1 idle cycle.
- Simultaneous events: req_last and the MAX_BURST limit in the same cycle cause a single end. A fifo_full rising in the same cycle as req_last means the word is not accepted and the burst continues.
- Changes on req of non-owners have no effect during BURST.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority in IDLE. If req[0]=1 it wins regardless of last_owner; the other requesters stay round-robin among themselves. A burst already in progress is never pre-empted.
- Undefined: pure round-robin as described above.

Test Plan:
- Reset then req=4'b1111, last on every word, fifo_full=0 -> grants in order 0,1,2,3,0; one word each; 1 idle cycle between grants; fifo_data equals each slice (e.g. 0xA0..0xA3).
- req=4'b0100 with req_last=0 held, MAX_BURST=4 -> exactly 4 fifo_wr pulses of requester 2's data, then gnt drops; re-grant to requester 2 after 1 idle cycle.
- In BURST at beat 1, hold fifo_full=1 for 3 cycles -> fifo_wr=0 and ack=0 for those 3 cycles; beat_cnt stays 1; the burst resumes and ends after 4 total words.
- Requester 1 drops req at beat 2 -> gnt[1] clears next edge; last_owner=1; a pending req[3] is granted next.
- Assert reset_n=0 mid-burst at beat 2 -> gnt=0, busy=0, fifo_wr=0 next cycle; after release with req=4'b1001, requester 0 is granted first.
- With FIFO_WR_ARB_PRIO0_EN and req=4'b0011, last on every word -> grant sequence 0,0,0 while req[0] stays high; without the macro -> 0,1,0,1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NUM_REQ
//   producers. A producer is granted for a burst of up to MAX_BURST words.
//   Its data is muxed onto the FIFO write interface. Writes are held off
//   while fifo_full is high.
//
//   Optional build macro FIFO_WR_ARB_PRIO0_EN: requester 0 wins every
//   arbitration it takes part in. The other requesters stay round-robin
//   among themselves. A running burst is never pre-empted.
//
//   state | meaning
//   IDLE  | no grant; picks the next requester when any req is set
//   BURST | owner holds the write port until last / MAX_BURST / withdraw
//
// Ports
//   clock, reset_n  system clock, synchronous active-low reset
//   req             per-requester request, held while data is available
//   req_data        packed requester data, slice i = [i*DATA_W +: DATA_W]
//   req_last        current word is the final word of the burst
//   gnt             registered one-hot grant
//   ack             word accepted this cycle (combinational)
//   fifo_full       FIFO full flag
//   fifo_wr         FIFO write strobe
//   fifo_data       FIFO write data
//   owner           index of the current grantee, 0 when idle
//   busy            high while in BURST
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    localparam int OW       = $clog2(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_data,
    output logic [OW-1:0]               owner,
    output logic                        busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nxt;
    logic [3:0]         beat_cnt, beat_nxt;
    logic [OW-1:0]      owner_nxt, last_owner, last_nxt, sel;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               sel_vld;
    logic               accept;
    logic               burst_end;
    logic               at_limit;
    int                 scan_idx;

    // Scan from the requester after the previous owner, with wrap, so the
    // one that just finished has the lowest priority.
    always_comb begin
        sel      = '0;
        sel_vld  = 1'b0;
        scan_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_owner) + k) % NUM_REQ;
            if (!sel_vld && req[scan_idx]) begin
                sel     = OW'(scan_idx);
                sel_vld = 1'b1;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req[0]) begin
            sel     = '0;
            sel_vld = 1'b1;
        end
`endif
    end

    // reset_n gates the write path so a burst cut by reset issues no write
    // in the reset cycle itself.
    assign busy      = (state == BURST);
    assign accept    = busy & reset_n & req[owner] & ~fifo_full;
    assign fifo_wr   = accept;
    assign ack       = accept ? (NUM_REQ'(1) << owner) : '0;
    assign fifo_data = (busy && reset_n) ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
    assign at_limit  = ({1'b0, beat_cnt} + 5'd1) == 5'(MAX_BURST);
    assign burst_end = busy & (~req[owner] | (accept & (req_last[owner] | at_limit)));

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        last_nxt  = last_owner;
        beat_nxt  = beat_cnt;
        unique case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt = BURST;
                    gnt_nxt   = NUM_REQ'(1) << sel;
                    owner_nxt = sel;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    owner_nxt = '0;
                    last_nxt  = owner;
                    beat_nxt  = '0;
                end else if (accept) begin
                    beat_nxt  = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                owner_nxt = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            last_owner <= OW'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            owner      <= owner_nxt;
            beat_cnt   <= beat_nxt;
            last_owner <= last_nxt;
        end
    end

endmodule
